ex_mdu_ctrl: RTL and testbench

- EX-stage sequencer for the RV32M extension; sits directly upstream of the iterative divider ex_mdu and alongside the EX ALU.
- Executes MUL/MULH/MULHSU/MULHU with an internal registered multiplier.
- Issues DIV/DIVU/REM/REMU to ex_mdu, holding start until ready.
- Stalls the pipeline while busy and presents one write-back pulse per completed instruction.

---
 rtl/ex_mdu_ctrl_pkg.sv | 46 ++++
 rtl/ex_mdu_ctrl_if.sv | 37 +++
 rtl/ex_mdu_ctrl_mul33.sv | 42 ++++
 rtl/ex_mdu_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ex_mdu_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mdu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ex_mdu_ctrl_pkg
//   Shared definitions for the RV32M execute-stage sequencer:
//     - funct3 opcodes of the M extension (MUL .. REMU)
//     - zero word constant
//     - small decode helpers for the multiplier operand signedness
//   Imported by the sequencer top and its multiplier sub-module.
// -----------------------------------------------------------------------------
package ex_mdu_ctrl_pkg;

  // funct3 field of OP/M instructions. Bit 2 splits multiply (0) from
  // divide/remainder (1).
  typedef enum logic [2:0] {
    INST_MUL    = 3'b000,
    INST_MULH   = 3'b001,
    INST_MULHSU = 3'b010,
    INST_MULHU  = 3'b011,
    INST_DIV    = 3'b100,
    INST_DIVU   = 3'b101,
    INST_REM    = 3'b110,
    INST_REMU   = 3'b111
  } mdu_op_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Operand A is treated as signed for MUL, MULH and MULHSU.
  function automatic logic rs1_is_signed(input logic [2:0] op);
    return (op == INST_MUL) || (op == INST_MULH) || (op == INST_MULHSU);
  endfunction

  // Operand B is treated as signed for MUL and MULH only.
  function automatic logic rs2_is_signed(input logic [2:0] op);
    return (op == INST_MUL) || (op == INST_MULH);
  endfunction

  // MUL returns the low word of the product; the other three the high word.
  function automatic logic mul_takes_low(input logic [2:0] op);
    return (op == INST_MUL);
  endfunction

  // Divider-path operations (DIV, DIVU, REM, REMU).
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/ex_mdu_ctrl_if.sv
// -----------------------------------------------------------------------------
// ex_mdu_ctrl_if
//   Point-to-point bus between the EX-stage sequencer (master) and the
//   iterative divider ex_mdu (slave).
//
//   master -> slave : dividend, divisor, start, op, waddr
//   slave -> master : result, ready, busy
//
//   start is a level: it stays high for as long as the sequencer waits for
//   the divider, and dropping it aborts an operation in flight. ready is a
//   single-cycle strobe that qualifies result.
// -----------------------------------------------------------------------------
interface ex_mdu_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) ();

  logic [XLEN-1:0]   dividend;
  logic [XLEN-1:0]   divisor;
  logic              start;
  logic [2:0]        op;
  logic [REG_AW-1:0] waddr;
  logic [XLEN-1:0]   result;
  logic              ready;
  logic              busy;

  modport master (
    output dividend, divisor, start, op, waddr,
    input  result, ready, busy
  );

  modport slave (
    input  dividend, divisor, start, op, waddr,
    output result, ready, busy
  );

endinterface

// File: rtl/ex_mdu_ctrl_mul33.sv
// -----------------------------------------------------------------------------
// ex_mul33
//   Registered signed multiplier, OPW x OPW -> 2*OPW, one cycle of latency.
//   With OPW = XLEN+1 the caller sign- or zero-extends each operand by one
//   bit, so a single signed array covers MUL, MULH, MULHSU and MULHU.
//   Kept as its own block so a multi-cycle implementation can replace it
//   without touching the sequencer.
//
//   Ports:
//     clk     core clock
//     rstn    asynchronous active-low reset, clears the product
//     en      load enable; product only updates while en is high
//     a, b    signed operands (already extended by the caller)
//     product registered signed product of a and b
// -----------------------------------------------------------------------------
module ex_mul33 #(
  parameter int OPW = 33
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic signed [OPW-1:0]   a,
  input  logic signed [OPW-1:0]   b,
  output logic signed [2*OPW-1:0] product
);

  logic signed [2*OPW-1:0] product_next;

  // Operands are widened first so the multiply is evaluated at full width.
  always_comb begin
    product_next = (2*OPW)'(a) * (2*OPW)'(b);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      product <= '0;
    end else if (en) begin
      product <= product_next;
    end
  end

endmodule

// File: rtl/ex_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// ex_mdu_ctrl
//   EX-stage sequencer for the RV32M extension.
//     - MUL/MULH/MULHSU/MULHU run on the internal registered multiplier
//       (request in cycle T, write-back pulse in cycle T+2).
//     - DIV/DIVU/REM/REMU are issued to ex_mdu over the div bus; start is
//       held until ex_mdu returns ready, whose result is written back as is.
//     - The pipeline is stalled (hold_o) while an instruction is in flight
//       and exactly one write-back pulse is produced per completed
//       instruction (none for rd = x0 or for a flushed instruction).
//
//   Ports:
//     clk, rstn        clock, asynchronous active-low reset
//     mdu_req_i        M instruction valid in EX
//     mdu_op_i         funct3 of the instruction
//     rs1_i, rs2_i     operands
//     rd_addr_i        destination register
//     flush_i          pipeline flush; kills whatever is in progress
//     div              master side of the bus to ex_mdu
//     hold_o           stall request (combinational)
//     wb_en_o          one-cycle write-back strobe
//     wb_addr_o        write-back register (valid with wb_en_o)
//     wb_data_o        write-back data (valid with wb_en_o)
// -----------------------------------------------------------------------------
module ex_mdu_ctrl
  import ex_mdu_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mdu_req_i,
  input  logic [2:0]        mdu_op_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              flush_i,
  ex_mdu_ctrl_if.master     div,
  output logic              hold_o,
  output logic              wb_en_o,
  output logic [REG_AW-1:0] wb_addr_o,
  output logic [XLEN-1:0]   wb_data_o
);

  // One-hot state encoding.
  localparam logic [3:0] S_IDLE     = 4'b0001;
  localparam logic [3:0] S_MUL      = 4'b0010;
  localparam logic [3:0] S_DIV_WAIT = 4'b0100;
  localparam logic [3:0] S_DONE     = 4'b1000;

  localparam int MW = XLEN + 1;

  logic [3:0]        state_reg;
  logic [3:0]        state_next;

  logic [2:0]        op_reg;
  logic [XLEN-1:0]   rs1_reg;
  logic [XLEN-1:0]   rs2_reg;
  logic [REG_AW-1:0] rd_reg;
  logic [XLEN-1:0]   div_result_reg;

  logic              st_idle;
  logic              st_mul;
  logic              st_div;
  logic              st_done;
  logic              accept;
  logic              div_capture;

  logic signed [MW-1:0]   mul_a;
  logic signed [MW-1:0]   mul_b;
  logic signed [2*MW-1:0] mul_product;
  logic [XLEN-1:0]        mul_result;
  logic [XLEN-1:0]        wb_data_sel;

  assign st_idle = state_reg[0];
  assign st_mul  = state_reg[1];
  assign st_div  = state_reg[2];
  assign st_done = state_reg[3];

  // A flush in the same cycle as a request means the instruction is being
  // squashed, so it is never latched.
  assign accept = st_idle && mdu_req_i && !flush_i;

  // A ready arriving together with a flush belongs to a killed instruction.
  assign div_capture = st_div && div.ready && !flush_i;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = op_is_div(mdu_op_i) ? S_DIV_WAIT : S_MUL;
        end
      end
      S_MUL: begin
        state_next = S_DONE;
      end
      S_DIV_WAIT: begin
        if (div.ready) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // A request visible here is the instruction that is completing now;
        // the next one can only be accepted from IDLE.
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (flush_i) begin
      state_next = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // State and operand registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= S_IDLE;
      op_reg         <= 3'b000;
      rs1_reg        <= '0;
      rs2_reg        <= '0;
      rd_reg         <= '0;
      div_result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg  <= mdu_op_i;
        rs1_reg <= rs1_i;
        rs2_reg <= rs2_i;
        rd_reg  <= rd_addr_i;
      end
      if (div_capture) begin
        div_result_reg <= div.result;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Multiplier: one extra bit per operand, filled with the sign bit or zero
  // depending on the opcode, lets one signed multiply serve all four forms.
  // ---------------------------------------------------------------------------
  assign mul_a = {rs1_is_signed(op_reg) & rs1_reg[XLEN-1], rs1_reg};
  assign mul_b = {rs2_is_signed(op_reg) & rs2_reg[XLEN-1], rs2_reg};

  ex_mul33 #(
    .OPW (MW)
  ) u_mul (
    .clk     (clk),
    .rstn    (rstn),
    .en      (st_mul),
    .a       (mul_a),
    .b       (mul_b),
    .product (mul_product)
  );

  assign mul_result = mul_takes_low(op_reg) ? mul_product[XLEN-1:0]
                                            : mul_product[2*XLEN-1:XLEN];

  assign wb_data_sel = op_is_div(op_reg) ? div_result_reg : mul_result;

  // ---------------------------------------------------------------------------
  // Divider bus: everything comes from the latched registers so it stays
  // constant for as long as start is high.
  // ---------------------------------------------------------------------------
  assign div.dividend = rs1_reg;
  assign div.divisor  = rs2_reg;
  assign div.op       = op_reg;
  assign div.waddr    = rd_reg;
  assign div.start    = st_div;

  // ---------------------------------------------------------------------------
  // Pipeline side
  // ---------------------------------------------------------------------------
  // hold is low in DONE so the instruction leaves EX on the DONE edge.
  // It is also masked by rstn so a request seen during reset cannot stall.
  assign hold_o = rstn && (st_mul || st_div || accept);

  assign wb_en_o   = st_done && !flush_i && (rd_reg != '0);
  assign wb_addr_o = st_done ? rd_reg      : '0;
  assign wb_data_o = st_done ? wb_data_sel : '0;

  // busy is informational only, and the top two product bits are just
  // sign extension of the 64-bit result.
  logic unused_bits;
  assign unused_bits = ^{div.busy, mul_product[2*MW-1:2*XLEN], ZERO_WORD};

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
`timescale 1ns/1ps
module tb_ex_mdu_ctrl;
  import ex_mdu_ctrl_pkg::*;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int DIV_LAT = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              mdu_req_i = 1'b0;
  logic [2:0]        mdu_op_i = 3'b000;
  logic [XLEN-1:0]   rs1_i = '0;
  logic [XLEN-1:0]   rs2_i = '0;
  logic [REG_AW-1:0] rd_addr_i = '0;
  logic              flush_i = 1'b0;
  logic              hold_o;
  logic              wb_en_o;
  logic [REG_AW-1:0] wb_addr_o;
  logic [XLEN-1:0]   wb_data_o;

  int checks = 0;
  int errors = 0;
  int busy_viol = 0;

  always #5 clk = ~clk;

  ex_mdu_ctrl_if #(.XLEN(XLEN), .REG_AW(REG_AW)) div_bus ();

  ex_mdu_ctrl #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mdu_req_i (mdu_req_i),
    .mdu_op_i  (mdu_op_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .rd_addr_i (rd_addr_i),
    .flush_i   (flush_i),
    .div       (div_bus),
    .hold_o    (hold_o),
    .wb_en_o   (wb_en_o),
    .wb_addr_o (wb_addr_o),
    .wb_data_o (wb_data_o)
  );

  // ---------------- behavioural ex_mdu (RISC-V divide semantics) ----------
  function automatic logic [31:0] div_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      3'b100: if (b == 0) r = 32'hFFFF_FFFF;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
              else r = $signed(a) / $signed(b);
      3'b110: if (b == 0) r = a;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
              else r = $signed(a) % $signed(b);
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b111: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic        running_q, ready_q;
  int          cnt_q;
  logic [31:0] result_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      running_q <= 1'b0; ready_q <= 1'b0; cnt_q <= 0; result_q <= '0;
    end else if (!div_bus.start) begin
      running_q <= 1'b0; ready_q <= 1'b0;
    end else if (ready_q) begin
      ready_q <= 1'b0;
    end else if (!running_q) begin
      running_q <= 1'b1; cnt_q <= DIV_LAT;
      result_q  <= div_ref(div_bus.op, div_bus.dividend, div_bus.divisor);
    end else if (cnt_q == 0) begin
      running_q <= 1'b0; ready_q <= 1'b1;
    end else begin
      cnt_q <= cnt_q - 1;
    end
  end

  assign div_bus.ready  = ready_q;
  assign div_bus.result = ready_q ? result_q : 32'hDEAD_BEEF;
  assign div_bus.busy   = running_q & div_bus.start;

  // divider must never report busy while the sequencer sits in IDLE
  always @(negedge clk) begin
    if (rstn && dut.state_reg == 4'b0001 && div_bus.busy) busy_viol++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int hold_cnt;
    bit done, start_gap, seen_ready;
    hold_cnt = 0; done = 0; start_gap = 0; seen_ready = 0;
    mdu_req_i = 1'b1; mdu_op_i = op; rs1_i = a; rs2_i = b; rd_addr_i = rd;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (hold_o) begin
        hold_cnt++;
        if (op[2] && hold_cnt > 1 && !div_bus.start) start_gap = 1;
        if (div_bus.ready && !seen_ready) begin
          seen_ready = 1;
          chk({name, " div_dividend"}, div_bus.dividend, a);
          chk({name, " div_divisor"}, div_bus.divisor, b);
          chk({name, " div_op_waddr"}, {24'd0, div_bus.op, div_bus.waddr}, {24'd0, op, rd});
        end
        @(negedge clk);
      end else begin
        done = 1;
        chk({name, " wb_en"}, {31'd0, wb_en_o}, {31'd0, rd != 0});
        if (rd != 0) begin
          chk({name, " wb_addr"}, {27'd0, wb_addr_o}, {27'd0, rd});
          chk({name, " wb_data"}, wb_data_o, exp);
        end
        chk({name, " start_in_done"}, {31'd0, div_bus.start}, 32'd0);
        if (op[2]) begin
          chk({name, " ready_seen"}, {31'd0, seen_ready}, 32'd1);
          chk({name, " start_held"}, {31'd0, start_gap}, 32'd0);
        end else begin
          chk({name, " hold_cycles"}, hold_cnt, 32'd2);
        end
        @(negedge clk);
        mdu_req_i = 1'b0;
        #1;
        chk({name, " wb_single_pulse"}, {31'd0, wb_en_o}, 32'd0);
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout actual=no_done required=done", name);
      mdu_req_i = 1'b0;
    end
    $display("txn %-8s rs1=%h rs2=%h rd=%0d hold=%0d wb_data=%h expect=%h", name, a, b, rd, hold_cnt, wb_data_o, exp);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];
  int   pulses;

  initial begin
    vecs[0]  = '{"MUL",    INST_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    vecs[1]  = '{"MULH",   INST_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFFF};
    vecs[2]  = '{"MULHU",  INST_MULHU,  32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'h0000_0006};
    vecs[3]  = '{"MULHSU", INST_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF};
    vecs[4]  = '{"MULOVF", INST_MUL,    32'h8000_0000, 32'h0000_0002, 5'd7,  32'h0000_0000};
    vecs[5]  = '{"DIV",    INST_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFD};
    vecs[6]  = '{"REM",    INST_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFF};
    vecs[7]  = '{"DIVU0",  INST_DIVU,   32'd100,       32'd0,         5'd10, 32'hFFFF_FFFF};
    vecs[8]  = '{"REMU0",  INST_REMU,   32'd100,       32'd0,         5'd11, 32'd100};
    vecs[9]  = '{"DIVOVF", INST_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000};
    vecs[10] = '{"B2BMUL", INST_MUL,    32'd6,         32'd7,         5'd3,  32'd42};
    vecs[11] = '{"B2BDIV", INST_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD};
    vecs[12] = '{"MULX0",  INST_MUL,    32'd5,         32'd5,         5'd0,  32'd25};

    // ---- reset state, with a request pending to prove hold is masked ----
    mdu_req_i = 1'b1; mdu_op_i = INST_DIV; rs1_i = 32'h1234_5678; rd_addr_i = 5'd1;
    repeat (3) @(negedge clk);
    chk("rst hold", {31'd0, hold_o}, 32'd0);
    chk("rst wb_en", {31'd0, wb_en_o}, 32'd0);
    chk("rst wb_data", wb_data_o, 32'd0);
    chk("rst start", {31'd0, div_bus.start}, 32'd0);
    chk("rst dividend", div_bus.dividend, 32'd0);
    mdu_req_i = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    #1;

    // ---- table-driven vectors (last three: back-to-back MUL, DIV, rd=x0) ----
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);
    end

    // ---- flush 10 cycles into a DIV ----
    mdu_req_i = 1'b1; mdu_op_i = INST_DIV; rs1_i = 32'd1000; rs2_i = 32'd7; rd_addr_i = 5'd13;
    repeat (10) @(negedge clk);
    #1;
    chk("flush pre start", {31'd0, div_bus.start}, 32'd1);
    flush_i = 1'b1;
    #1;
    chk("flush wb_en", {31'd0, wb_en_o}, 32'd0);
    @(negedge clk);
    #1;
    flush_i = 1'b0; mdu_req_i = 1'b0;
    #1;
    chk("flush idle hold", {31'd0, hold_o}, 32'd0);
    chk("flush start drop", {31'd0, div_bus.start}, 32'd0);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (wb_en_o) pulses++;
    end
    chk("flush no wb", pulses, 32'd0);
    #1;
    $display("txn FLUSH    DIV rd=13 flushed after 10 cycles");
    run_op("DIV20_3", INST_DIV, 32'd20, 32'd3, 5'd14, 32'd6);

    // ---- flush coincident with ready ----
    mdu_req_i = 1'b1; mdu_op_i = INST_DIVU; rs1_i = 32'd100; rs2_i = 32'd7; rd_addr_i = 5'd15;
    for (int c = 0; c < 100 && !div_bus.ready; c++) begin
      @(negedge clk);
      #1;
    end
    chk("flushrdy ready", {31'd0, div_bus.ready}, 32'd1);
    flush_i = 1'b1;
    #1;
    chk("flushrdy wb_en now", {31'd0, wb_en_o}, 32'd0);
    @(negedge clk);
    #1;
    chk("flushrdy wb_en next", {31'd0, wb_en_o}, 32'd0);
    flush_i = 1'b0; mdu_req_i = 1'b0;
    #1;
    chk("flushrdy hold", {31'd0, hold_o}, 32'd0);
    $display("txn FLUSHRDY DIVU rd=15 flushed with ready");

    // ---- reset asserted mid-divide ----
    mdu_req_i = 1'b1; mdu_op_i = INST_REM; rs1_i = 32'd50; rs2_i = 32'd9; rd_addr_i = 5'd16;
    repeat (5) @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst hold", {31'd0, hold_o}, 32'd0);
    chk("midrst start", {31'd0, div_bus.start}, 32'd0);
    chk("midrst wb_en", {31'd0, wb_en_o}, 32'd0);
    @(negedge clk);
    rstn = 1'b1; mdu_req_i = 1'b0;
    @(negedge clk);
    #1;
    $display("txn MIDRST   REM rd=16 aborted by reset");
    run_op("AFTERRST", INST_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE);

    chk("busy_in_idle", busy_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
